// File: rtl/counter_seq_checker.sv
// counter_seq_checker: passive monitor that locks onto an incrementing count bus and flags sequence breaks
module counter_seq_checker #(
  parameter int WIDTH       = 4,
  parameter int LOCK_CYCLES = 2,
  parameter int ERR_CNT_W   = 8,
  parameter int WRAP_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      count,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  err_flag,
  output logic [WIDTH-1:0]      exp_count,
  output logic [WIDTH-1:0]      bad_count,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] prev, nxt;
  logic [3:0] run, run_n;
  logic hit, miss, wrap;
  assign nxt  = prev + WIDTH'(1);
  assign hit  = count == nxt;
  assign miss = en && state == LOCKED && !hit;
  assign wrap = en && state == LOCKED && hit && prev == '1;
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    run_n   = run;
    if (!en) state_n = IDLE;
    else if (state == IDLE) begin
      state_n = ACQUIRE;
      run_n   = '0;
    end else if (state == ACQUIRE) begin
      run_n   = hit ? run + 4'd1 : 4'd0;
      state_n = (hit && run_n == 4'(LOCK_CYCLES)) ? LOCKED : ACQUIRE;
    end
  end
  // statistics survive en=0; only clr or reset wipes them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prev      <= '0;
      run       <= '0;
      err_pulse <= 1'b0;
      err_flag  <= 1'b0;
      exp_count <= '0;
      bad_count <= '0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
    end else begin
      state     <= state_n;
      prev      <= en ? count : prev;
      run       <= run_n;
      err_pulse <= miss;
      err_flag  <= clr ? 1'b0 : err_flag | miss;
      exp_count <= clr ? '0 : miss ? nxt : exp_count;
      bad_count <= clr ? '0 : miss ? count : bad_count;
      err_cnt   <= clr ? '0 : (miss && !(&err_cnt)) ? err_cnt + ERR_CNT_W'(1) : err_cnt;
      wrap_cnt  <= clr ? '0 : (wrap && !(&wrap_cnt)) ? wrap_cnt + WRAP_CNT_W'(1) : wrap_cnt;
    end
  end
endmodule

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: directed checks of lock, wrap, mismatch capture, saturation, clear and reset
module tb_counter_seq_checker;
  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [3:0]  count;
  logic        locked, err_pulse, err_flag;
  logic [3:0]  exp_count, bad_count;
  logic [7:0]  err_cnt;
  logic [15:0] wrap_cnt;
  int total = 0;
  int bad = 0;

  counter_seq_checker dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .count(count),
    .locked(locked), .err_pulse(err_pulse), .err_flag(err_flag),
    .exp_count(exp_count), .bad_count(bad_count),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] v);
    count = v;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".pulse"}, err_pulse, 0);
    chk({tag, ".flag"}, err_flag, 0);
    chk({tag, ".exp"}, exp_count, 0);
    chk({tag, ".bad"}, bad_count, 0);
    chk({tag, ".ecnt"}, err_cnt, 0);
    chk({tag, ".wcnt"}, wrap_cnt, 0);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; count = '0;
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom_range(0, 1));
      step(4'($urandom_range(0, 15)));
      all_zero("rst");
    end
    en = 1'b0;
    reset = 1'b1;
    step(4'd7);
    step(4'd8);
    all_zero("idle");

    en = 1'b1;
    step(4'd0);
    chk("acq0.locked", locked, 0);
    step(4'd1);
    chk("acq1.locked", locked, 0);
    step(4'd2);
    chk("lock.locked", locked, 1);
    for (int v = 3; v < 16; v++) begin
      step(4'(v));
      chk("run.ecnt", err_cnt, 0);
      chk("run.flag", err_flag, 0);
    end
    chk("prewrap.wcnt", wrap_cnt, 0);
    step(4'd0);
    chk("wrap.wcnt", wrap_cnt, 1);
    step(4'd1);
    chk("wrap1.flag", err_flag, 0);
    chk("wrap1.ecnt", err_cnt, 0);

    step(4'd2); step(4'd3); step(4'd4); step(4'd5);
    step(4'd6);
    chk("skip6.pulse", err_pulse, 0);
    step(4'd8);
    chk("skip.pulse", err_pulse, 1);
    chk("skip.flag", err_flag, 1);
    chk("skip.exp", exp_count, 7);
    chk("skip.bad", bad_count, 8);
    chk("skip.ecnt", err_cnt, 1);
    step(4'd9);
    chk("skip9.pulse", err_pulse, 0);
    chk("skip9.ecnt", err_cnt, 1);

    clr = 1'b1;
    step(4'd10);
    clr = 1'b0;
    chk("clr1.ecnt", err_cnt, 0);
    chk("clr1.bad", bad_count, 0);
    for (int v = 11; v < 16; v++) step(4'(v));
    step(4'd0); step(4'd1); step(4'd2); step(4'd3);
    chk("hold0.pulse", err_pulse, 0);
    step(4'd3);
    chk("hold.pulse", err_pulse, 1);
    chk("hold.exp", exp_count, 4);
    chk("hold.bad", bad_count, 3);
    step(4'd4);
    chk("hold4.pulse", err_pulse, 0);
    step(4'd5); step(4'd6); step(4'd7);
    step(4'd0);
    chk("jump.pulse", err_pulse, 1);
    chk("jump.ecnt", err_cnt, 2);
    chk("jump.exp", exp_count, 8);
    chk("jump.bad", bad_count, 0);
    chk("jump.wcnt", wrap_cnt, 1);

    for (int i = 0; i < 300; i++) step((i % 2) ? 4'd0 : 4'd5);
    chk("sat.ecnt", err_cnt, 255);
    chk("sat.pulse", err_pulse, 1);
    clr = 1'b1;
    step(4'd1);
    chk("clr.ecnt", err_cnt, 0);
    chk("clr.flag", err_flag, 0);
    chk("clr.wcnt", wrap_cnt, 0);
    chk("clr.locked", locked, 1);
    step(4'd1);
    clr = 1'b0;
    chk("clrmiss.pulse", err_pulse, 1);
    chk("clrmiss.ecnt", err_cnt, 0);
    chk("clrmiss.flag", err_flag, 0);

    step(4'd1); step(4'd1); step(4'd1);
    chk("pre_ar.ecnt", err_cnt, 3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 all_zero("arst");
    @(negedge clk);
    reset = 1'b1;
    en = 1'b1;
    step(4'd0);
    step(4'd1);
    chk("relock1.locked", locked, 0);
    step(4'd2);
    chk("relock.locked", locked, 1);
    step(4'd2); step(4'd2); step(4'd2);
    chk("en0pre.ecnt", err_cnt, 3);
    en = 1'b0;
    step(4'd3);
    chk("en0.locked", locked, 0);
    chk("en0.ecnt", err_cnt, 3);
    chk("en0.flag", err_flag, 1);
    chk("en0.pulse", err_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
